phase_ctl: RTL

PHASE_CTL -- requirements
Module: phase_ctl

---
 rtl/ji3_pkg.sv | 30 +++
 rtl/instret_cnt.sv | 24 ++
 rtl/phase_ctl.sv | 93 +++++++++
 3 files changed

// File: rtl/ji3_pkg.sv
// rtl/ji3_pkg.sv - shared phase indices, opcodes and control state encoding
package ji3_pkg;

    // Bit positions of each phase in the one-hot phase vector
    localparam int PH_F = 0;
    localparam int PH_R = 1;
    localparam int PH_X = 2;
    localparam int PH_M = 3;
    localparam int PH_W = 4;

    // Decoded opcodes the sequencer cares about
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_LD  = 4'b1100;
    localparam logic [3:0] OP_ST  = 4'b1101;
    localparam logic [3:0] OP_LIL = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } ctl_state_e;

    // A phase waits on memory: fetch always, execute for stores, memory for loads
    function automatic logic is_mem_phase(input logic f, input logic x,
                                          input logic m, input logic [3:0] op);
        return f | (x & (op == OP_ST)) | (m & (op == OP_LD));
    endfunction

endpackage

// File: rtl/instret_cnt.sv
// rtl/instret_cnt.sv - wrapping retired-instruction counter
module instret_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    // Count one per enabled cycle; wraps silently at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/phase_ctl.sv
// rtl/phase_ctl.sv - five-phase instruction sequencer with stall and halt
module phase_ctl
    import ji3_pkg::*;
#(
    parameter int W_PH  = 5,
    parameter int W_CNT = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic             mem_ready,
    output logic [W_PH-1:0]  phase,
    output logic             ir_en,
    output logic             pc_en,
    output logic             stall,
    output logic             halted,
    output logic             busy,
    output logic [W_CNT-1:0] instret
);

    localparam logic [W_PH-1:0] PH_ONE   = W_PH'(1);
    localparam logic [W_PH-1:0] PH_F_VEC = PH_ONE << PH_F;

    ctl_state_e      state_q, state_d;
    logic [W_PH-1:0] phase_q, phase_d;
    logic            mem_wait;

    // State and phase registers; phase is kept all-zero outside RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    // Next state, phase advance and per-cycle strobes
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        ir_en    = 1'b0;
        pc_en    = 1'b0;
        stall    = 1'b0;
        mem_wait = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d = ST_RUN;
                    phase_d = PH_F_VEC;
                end
            end
            ST_RUN: begin
                mem_wait = is_mem_phase(phase_q[PH_F], phase_q[PH_X], phase_q[PH_M], op)
                           & ~mem_ready;
                if (mem_wait) begin
                    stall = 1'b1;
                end else begin
                    ir_en = phase_q[PH_F];
                    if (phase_q[PH_W]) begin
                        if (op == OP_HLT) begin
                            state_d = ST_HALT;
                            phase_d = '0;
                        end else begin
                            pc_en   = 1'b1;
                            phase_d = PH_F_VEC;
                        end
                    end else begin
                        phase_d = phase_q << 1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
        endcase
    end

    assign phase  = phase_q;
    assign busy   = (state_q == ST_RUN);
    assign halted = (state_q == ST_HALT);

    instret_cnt #(.W(W_CNT)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pc_en),
        .count (instret)
    );

endmodule
